// File: rtl/rv_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// rv_ctrl_pkg
//   Shared definitions for the multicycle RV32I control unit: FSM state
//   encoding, opcode constants, immediate-format codes, ALU operation codes,
//   datapath mux-select encodings and the branch-condition helper.
// ----------------------------------------------------------------------------
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECR,
        S_EXECI,
        S_ALUWB,
        S_BRANCH,
        S_JAL,
        S_JALR,
        S_LUI,
        S_AUIPC,
        S_TRAP
    } state_t;

    // Class of ALU operation requested by the FSM; the ALU decoder expands it.
    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    // Opcodes (instr[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Immediate formats for the extend unit
    localparam logic [2:0] IMM_SHAMT = 3'b000;
    localparam logic [2:0] IMM_I     = 3'b001;
    localparam logic [2:0] IMM_S     = 3'b010;
    localparam logic [2:0] IMM_B     = 3'b011;
    localparam logic [2:0] IMM_U     = 3'b100;
    localparam logic [2:0] IMM_J     = 3'b101;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    // ALU operand A select
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    // ALU operand B select
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;
    localparam logic [1:0] SRCB_UIMM = 2'b11;

    // Result mux select
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Branch condition from funct3 and the same-cycle compare flags.
    // funct3 010/011 are not valid branches and never redirect the PC.
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic       zero,
                                          input logic       lt,
                                          input logic       ltu);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return !zero;
            3'b100:  return lt;
            3'b101:  return !lt;
            3'b110:  return ltu;
            3'b111:  return !ltu;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
//   Control/status bundle between the multicycle controller and its datapath.
//   Datapath -> controller: op, funct3, funct7b5, zero, lt, ltu, mem_ready.
//   Controller -> datapath: immsrc, alusrca, alusrcb, alucontrol, resultsrc,
//                           adrsrc, irwrite, pcwrite, regwrite, memwrite,
//                           illegal.
//   master = controller side, slave = datapath side.
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       lt;
    logic       ltu;
    logic       mem_ready;

    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [3:0] alucontrol;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        output immsrc, alusrca, alusrcb, alucontrol, resultsrc,
               adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, lt, ltu, mem_ready,
        input  immsrc, alusrca, alusrcb, alucontrol, resultsrc,
               adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal
    );
endinterface

// File: rtl/alu_decoder.sv
// ----------------------------------------------------------------------------
// alu_decoder
//   Combinational expansion of the FSM's ALU operation class into an ALU code.
//   Ports:
//     aluop      in  operation class (ADD / SUB / from funct fields)
//     funct3     in  instr[14:12]
//     funct7b5   in  instr[30]
//     op5        in  instr[5]; 1 for R-type, 0 for I-type ALU ops
//     alucontrol out ALU operation code
// ----------------------------------------------------------------------------
module alu_decoder
    import rv_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [3:0] alucontrol
);

    // NOTE: every output gets a default at the top of an always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // In I-type, instr[30] is an immediate bit, so only R-type may select SUB.
                    3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  alucontrol = ALU_SLL;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b011:  alucontrol = ALU_SLTU;
                    3'b100:  alucontrol = ALU_XOR;
                    // SRA and SRAI both carry funct7b5 = 1.
                    3'b101:  alucontrol = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alucontrol = ALU_OR;
                    default: alucontrol = ALU_AND;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//   Multicycle RV32I control FSM for a shared-ALU datapath. Steps each
//   instruction through FETCH / DECODE / EXECUTE / writeback states, holding
//   in memory states until mem_ready, and traps on illegal opcodes.
//   Parameters:
//     ENABLE_TRAP 1: illegal opcode -> TRAP (sticky until reset)
//                 0: illegal opcode -> back to FETCH with no writes
//   Ports:
//     clk    in  rising-edge clock
//     reset  in  asynchronous, active-high reset
//     bus    master side of multicycle_ctrl_if (decode inputs, flags,
//            mem_ready in; mux selects and write enables out)
// ----------------------------------------------------------------------------
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter bit ENABLE_TRAP = 1'b1
) (
    input logic                 clk,
    input logic                 reset,
    multicycle_ctrl_if.master   bus
);

    state_t     state;
    aluop_t     aluop;
    logic [2:0] immsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;

    // ------------------------------------------------------------------
    // State register and next-state logic
    // ------------------------------------------------------------------
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH:    if (bus.mem_ready) state <= S_DECODE;
                S_DECODE: begin
                    case (bus.op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_R:              state <= S_EXECR;
                        OP_I:              state <= S_EXECI;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR;
                        OP_LUI:            state <= S_LUI;
                        OP_AUIPC:          state <= S_AUIPC;
                        default:           state <= ENABLE_TRAP ? S_TRAP : S_FETCH;
                    endcase
                end
                // Only loads and stores reach MEMADR; op[5] tells them apart.
                S_MEMADR:   state <= bus.op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (bus.mem_ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (bus.mem_ready) state <= S_FETCH;
                S_EXECR,
                S_EXECI,
                S_LUI,
                S_AUIPC:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= S_FETCH;
                S_JAL:      state <= S_ALUWB;
                // aluout now holds rs1+imm; JAL commits it to the PC and
                // computes the link value.
                S_JALR:     state <= S_JAL;
                S_TRAP:     state <= S_TRAP;
                default:    state <= S_FETCH;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode
    // ------------------------------------------------------------------
    // Outputs depend on same-cycle mem_ready and compare flags, so they are
    // decoded combinationally from the state register. Gating with reset
    // drops every enable the instant reset asserts, so an access in flight
    // never completes a write.
    always_comb begin
        immsrc    = IMM_I;
        alusrca   = SRCA_PC;
        alusrcb   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        resultsrc = RES_ALUOUT;
        adrsrc    = 1'b0;
        irwrite   = 1'b0;
        pcwrite   = 1'b0;
        regwrite  = 1'b0;
        memwrite  = 1'b0;
        illegal   = 1'b0;
        if (!reset) begin
            case (state)
                S_FETCH: begin
                    alusrcb   = SRCB_FOUR;
                    resultsrc = RES_ALU;
                    irwrite   = bus.mem_ready;
                    pcwrite   = bus.mem_ready;
                end
                S_DECODE: begin
                    // Precompute the branch/jal target into aluout.
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_IMM;
                    if (bus.op == OP_BRANCH)   immsrc = IMM_B;
                    else if (bus.op == OP_JAL) immsrc = IMM_J;
                end
                S_MEMADR: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                    if (bus.op[5]) immsrc = IMM_S;
                end
                S_MEMREAD: adrsrc = 1'b1;
                S_MEMWB: begin
                    resultsrc = RES_MEM;
                    regwrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    adrsrc   = 1'b1;
                    memwrite = 1'b1;
                end
                S_EXECR: begin
                    alusrca = SRCA_RS1;
                    aluop   = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                    aluop   = ALUOP_FUNCT;
                    // Shift-immediates take the 5-bit shamt format.
                    if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101) immsrc = IMM_SHAMT;
                end
                S_ALUWB:  regwrite = 1'b1;
                S_BRANCH: begin
                    alusrca = SRCA_RS1;
                    aluop   = ALUOP_SUB;
                    pcwrite = branch_taken(bus.funct3, bus.zero, bus.lt, bus.ltu);
                end
                S_JAL: begin
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_FOUR;
                    pcwrite = 1'b1;
                end
                S_JALR: begin
                    alusrca = SRCA_RS1;
                    alusrcb = SRCB_IMM;
                end
                S_LUI: begin
                    immsrc  = IMM_U;
                    alusrca = SRCA_ZERO;
                    alusrcb = SRCB_UIMM;
                end
                S_AUIPC: begin
                    immsrc  = IMM_U;
                    alusrca = SRCA_OLDPC;
                    alusrcb = SRCB_UIMM;
                end
                S_TRAP:  illegal = 1'b1;
                default: ;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (bus.funct3),
        .funct7b5   (bus.funct7b5),
        .op5        (bus.op[5]),
        .alucontrol (bus.alucontrol)
    );

    assign bus.immsrc    = immsrc;
    assign bus.alusrca   = alusrca;
    assign bus.alusrcb   = alusrcb;
    assign bus.resultsrc = resultsrc;
    assign bus.adrsrc    = adrsrc;
    assign bus.irwrite   = irwrite;
    assign bus.pcwrite   = pcwrite;
    assign bus.regwrite  = regwrite;
    assign bus.memwrite  = memwrite;
    assign bus.illegal   = illegal;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//   Directed bench for multicycle_ctrl. Two instances: one with the trap
//   enabled, one without. Inputs change on the falling edge and outputs are
//   sampled 1 time unit later, well away from the rising edge.
//   Output vector layout: {immsrc, alusrca, alusrcb, alucontrol, resultsrc,
//                          adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal}
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    multicycle_ctrl_if bus ();
    multicycle_ctrl_if bus_nt ();

    multicycle_ctrl #(.ENABLE_TRAP(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    multicycle_ctrl #(.ENABLE_TRAP(1'b0)) dut_nt (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nt.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [18:0] outs, outs_nt;
    assign outs    = {bus.immsrc, bus.alusrca, bus.alusrcb, bus.alucontrol, bus.resultsrc,
                      bus.adrsrc, bus.irwrite, bus.pcwrite, bus.regwrite, bus.memwrite, bus.illegal};
    assign outs_nt = {bus_nt.immsrc, bus_nt.alusrca, bus_nt.alusrcb, bus_nt.alucontrol, bus_nt.resultsrc,
                      bus_nt.adrsrc, bus_nt.irwrite, bus_nt.pcwrite, bus_nt.regwrite, bus_nt.memwrite,
                      bus_nt.illegal};

    // en = {adrsrc, irwrite, pcwrite, regwrite, memwrite, illegal}
    function automatic logic [18:0] ev(input logic [2:0] imm, input logic [1:0] a, input logic [1:0] b,
                                       input logic [3:0] alu, input logic [1:0] res, input logic [5:0] en);
        return {imm, a, b, alu, res, en};
    endfunction

    // Hand-derived expected output vectors per state
    logic [18:0] RST, F1, F0, DEC_I, DEC_B, DEC_J, EXECI_ADD, MA_L, MA_S, MEMREAD, MEMWB, MEMWR;
    logic [18:0] ALUWB, JALS, JALRS, LUIS, AUIPCS, TRAPS;

    task automatic set_instr(input logic [31:0] w);
        bus.op       = w[6:0];
        bus.funct3   = w[14:12];
        bus.funct7b5 = w[30];
    endtask

    task automatic test_reset();
        bus.mem_ready    = 1'b1;
        bus.zero         = 1'b0;
        bus.lt           = 1'b0;
        bus.ltu          = 1'b0;
        set_instr(32'h00500093);
        bus_nt.mem_ready = 1'b1;
        bus_nt.zero      = 1'b0;
        bus_nt.lt        = 1'b0;
        bus_nt.ltu       = 1'b0;
        bus_nt.op        = 7'h13;
        bus_nt.funct3    = 3'b000;
        bus_nt.funct7b5  = 1'b0;
        #1;
        tests++;
        if (outs !== RST) begin
            fails++;
            $display("FAIL reset: got %h expected %h", outs, RST);
        end
        tests++;
        if (outs_nt !== RST) begin
            fails++;
            $display("FAIL reset_nt: got %h expected %h", outs_nt, RST);
        end
        // Hold the no-trap instance in FETCH until its own test.
        bus_nt.mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_addi();
        logic [18:0] exp[4];
        exp = '{F1, DEC_I, EXECI_ADD, ALUWB};
        set_instr(32'h00500093);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL addi cyc%0d: got %h expected %h", i, outs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] words[11];
        logic [18:0] ex[11];
        logic [18:0] seq[4];
        words = '{32'h00309093, 32'h4030D093, 32'h0030D093, 32'h40000093, 32'h40208033, 32'h00208033,
                  32'h4020D033, 32'h0020B033, 32'h0020F033, 32'h0040C093, 32'h00402093};
        ex = '{ev(3'b000, 2'b10, 2'b01, 4'b0010, 2'b00, 6'b0),   // slli  -> SLL, shamt
               ev(3'b000, 2'b10, 2'b01, 4'b0111, 2'b00, 6'b0),   // srai  -> SRA, shamt
               ev(3'b000, 2'b10, 2'b01, 4'b0110, 2'b00, 6'b0),   // srli  -> SRL, shamt
               ev(3'b001, 2'b10, 2'b01, 4'b0000, 2'b00, 6'b0),   // addi with instr[30]=1 stays ADD
               ev(3'b001, 2'b10, 2'b00, 4'b0001, 2'b00, 6'b0),   // sub
               ev(3'b001, 2'b10, 2'b00, 4'b0000, 2'b00, 6'b0),   // add
               ev(3'b001, 2'b10, 2'b00, 4'b0111, 2'b00, 6'b0),   // sra
               ev(3'b001, 2'b10, 2'b00, 4'b0100, 2'b00, 6'b0),   // sltu
               ev(3'b001, 2'b10, 2'b00, 4'b1001, 2'b00, 6'b0),   // and
               ev(3'b001, 2'b10, 2'b01, 4'b0101, 2'b00, 6'b0),   // xori
               ev(3'b001, 2'b10, 2'b01, 4'b0011, 2'b00, 6'b0)};  // slti
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            set_instr(words[k]);
            seq = '{F1, DEC_I, ex[k], ALUWB};
            for (int i = 0; i < 4; i++) begin
                #1;
                tests++;
                if (outs !== seq[i]) begin
                    fails++;
                    $display("FAIL alu_op %h cyc%0d: got %h expected %h", words[k], i, outs, seq[i]);
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_branch();
        logic [31:0] words[9];
        logic [2:0]  flags[9];   // {zero, lt, ltu}
        logic        taken[9];
        logic [18:0] seq[3];
        words = '{32'h00000463, 32'h00000463, 32'h00001463, 32'h00004463, 32'h00005463,
                  32'h00006463, 32'h00007463, 32'h00007463, 32'h00002463};
        flags = '{3'b100, 3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b000, 3'b001, 3'b111};
        taken = '{1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b1,   1'b1,   1'b0,   1'b0};
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            set_instr(words[k]);
            {bus.zero, bus.lt, bus.ltu} = flags[k];
            seq = '{F1, DEC_B, ev(3'b001, 2'b10, 2'b00, 4'b0001, 2'b00, {2'b00, taken[k], 3'b000})};
            for (int i = 0; i < 3; i++) begin
                #1;
                tests++;
                if (outs !== seq[i]) begin
                    fails++;
                    $display("FAIL branch %0d cyc%0d: got %h expected %h", k, i, outs, seq[i]);
                end
                @(negedge clk);
            end
        end
        {bus.zero, bus.lt, bus.ltu} = 3'b000;
    endtask

    task automatic test_lw_wait();
        logic [18:0] exp[8];
        logic        rdy[8];
        exp = '{F1, DEC_I, MA_L, MEMREAD, MEMREAD, MEMREAD, MEMREAD, MEMWB};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        set_instr(32'h00002083);
        for (int i = 0; i < 8; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL lw cyc%0d: got %h expected %h", i, outs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sw_wait();
        logic [18:0] exp[5];
        logic        rdy[5];
        exp = '{F1, DEC_I, MA_S, MEMWR, MEMWR};
        rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        set_instr(32'h00102023);
        for (int i = 0; i < 5; i++) begin
            bus.mem_ready = rdy[i];
            #1;
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL sw cyc%0d: got %h expected %h", i, outs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_jumps();
        logic [18:0] ej[4];
        logic [18:0] er[5];
        bus.mem_ready = 1'b1;
        ej = '{F1, DEC_J, JALS, ALUWB};
        set_instr(32'h0080006F);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (outs !== ej[i]) begin
                fails++;
                $display("FAIL jal cyc%0d: got %h expected %h", i, outs, ej[i]);
            end
            @(negedge clk);
        end
        er = '{F1, DEC_I, JALRS, JALS, ALUWB};
        set_instr(32'h000080E7);
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (outs !== er[i]) begin
                fails++;
                $display("FAIL jalr cyc%0d: got %h expected %h", i, outs, er[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_upper();
        logic [18:0] el[4];
        logic [18:0] ea[4];
        bus.mem_ready = 1'b1;
        el = '{F1, DEC_I, LUIS, ALUWB};
        set_instr(32'h12345037);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (outs !== el[i]) begin
                fails++;
                $display("FAIL lui cyc%0d: got %h expected %h", i, outs, el[i]);
            end
            @(negedge clk);
        end
        ea = '{F1, DEC_I, AUIPCS, ALUWB};
        set_instr(32'h00000017);
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (outs !== ea[i]) begin
                fails++;
                $display("FAIL auipc cyc%0d: got %h expected %h", i, outs, ea[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_trap();
        logic [18:0] exp[6];
        exp = '{F1, DEC_I, TRAPS, TRAPS, TRAPS, TRAPS};
        bus.mem_ready = 1'b1;
        set_instr(32'h0000007F);
        for (int i = 0; i < 6; i++) begin
            #1;
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL trap cyc%0d: got %h expected %h", i, outs, exp[i]);
            end
            @(negedge clk);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (outs !== RST) begin
            fails++;
            $display("FAIL trap_reset: got %h expected %h", outs, RST);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++;
        if (outs !== F1) begin
            fails++;
            $display("FAIL trap_refetch: got %h expected %h", outs, F1);
        end
        // Keep the trap instance parked in FETCH during the next test.
        bus.mem_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_no_trap();
        logic [18:0] exp[4];
        logic        rdy[4];
        exp = '{F1, DEC_I, F0, F0};
        rdy = '{1'b1, 1'b1, 1'b0, 1'b0};
        bus_nt.op       = 7'h7F;
        bus_nt.funct3   = 3'b000;
        bus_nt.funct7b5 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_nt.mem_ready = rdy[i];
            #1;
            tests++;
            if (outs_nt !== exp[i]) begin
                fails++;
                $display("FAIL no_trap cyc%0d: got %h expected %h", i, outs_nt, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [18:0] exp[3];
        exp = '{F1, DEC_I, MA_S};
        set_instr(32'h00102023);
        bus.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL rst_sw cyc%0d: got %h expected %h", i, outs, exp[i]);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b0;
        #1;
        tests++;
        if (outs !== MEMWR) begin
            fails++;
            $display("FAIL rst_sw memwrite: got %h expected %h", outs, MEMWR);
        end
        #1 reset = 1'b1;
        #1;
        tests++;
        if (outs !== RST) begin
            fails++;
            $display("FAIL rst_sw drop: got %h expected %h", outs, RST);
        end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (outs !== F0) begin
                fails++;
                $display("FAIL rst_sw fetch_wait%0d: got %h expected %h", i, outs, F0);
            end
            @(negedge clk);
        end
        bus.mem_ready = 1'b1;
        #1;
        tests++;
        if (outs !== F1) begin
            fails++;
            $display("FAIL rst_sw fetch_ready: got %h expected %h", outs, F1);
        end
    endtask

    initial begin
        RST       = ev(3'b001, 2'b00, 2'b00, 4'b0000, 2'b00, 6'b000000);
        F1        = ev(3'b001, 2'b00, 2'b10, 4'b0000, 2'b10, 6'b011000);
        F0        = ev(3'b001, 2'b00, 2'b10, 4'b0000, 2'b10, 6'b000000);
        DEC_I     = ev(3'b001, 2'b01, 2'b01, 4'b0000, 2'b00, 6'b000000);
        DEC_B     = ev(3'b011, 2'b01, 2'b01, 4'b0000, 2'b00, 6'b000000);
        DEC_J     = ev(3'b101, 2'b01, 2'b01, 4'b0000, 2'b00, 6'b000000);
        EXECI_ADD = ev(3'b001, 2'b10, 2'b01, 4'b0000, 2'b00, 6'b000000);
        MA_L      = ev(3'b001, 2'b10, 2'b01, 4'b0000, 2'b00, 6'b000000);
        MA_S      = ev(3'b010, 2'b10, 2'b01, 4'b0000, 2'b00, 6'b000000);
        MEMREAD   = ev(3'b001, 2'b00, 2'b00, 4'b0000, 2'b00, 6'b100000);
        MEMWB     = ev(3'b001, 2'b00, 2'b00, 4'b0000, 2'b01, 6'b000100);
        MEMWR     = ev(3'b001, 2'b00, 2'b00, 4'b0000, 2'b00, 6'b100010);
        ALUWB     = ev(3'b001, 2'b00, 2'b00, 4'b0000, 2'b00, 6'b000100);
        JALS      = ev(3'b001, 2'b01, 2'b10, 4'b0000, 2'b00, 6'b001000);
        JALRS     = ev(3'b001, 2'b10, 2'b01, 4'b0000, 2'b00, 6'b000000);
        LUIS      = ev(3'b100, 2'b11, 2'b11, 4'b0000, 2'b00, 6'b000000);
        AUIPCS    = ev(3'b100, 2'b01, 2'b11, 4'b0000, 2'b00, 6'b000000);
        TRAPS     = ev(3'b001, 2'b00, 2'b00, 4'b0000, 2'b00, 6'b000001);

        test_reset();
        test_addi();
        test_alu_ops();
        test_branch();
        test_lw_wait();
        test_sw_wait();
        test_jumps();
        test_upper();
        test_trap();
        test_no_trap();
        test_reset_mid_store();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
